// File: rtl/decode_if.sv
// Bundle between decode_stage and its neighbours: fetch inputs, write-back
// port and the registered decode results consumed by execute.
interface decode_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [3:0]        start;
    logic [DATA_W-1:0] ir_i;
    logic [DATA_W-1:0] npc_i;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] ir_o;
    logic [DATA_W-1:0] npc_o;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm_ext;
    logic [REG_AW-1:0] rd_addr;
    logic [2:0]        op_class;
    logic [DATA_W-1:0] br_target;
    logic [DATA_W-1:0] j_target;
    logic              dec_valid;
    logic              illegal;

    modport master (
        output start, ir_i, npc_i, wb_en, wb_addr, wb_data,
        input  ir_o, npc_o, rs_data, rt_data, imm_ext, rd_addr, op_class,
               br_target, j_target, dec_valid, illegal
    );

    modport slave (
        input  start, ir_i, npc_i, wb_en, wb_addr, wb_data,
        output ir_o, npc_o, rs_data, rt_data, imm_ext, rd_addr, op_class,
               br_target, j_target, dec_valid, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage with 32x32 register file; all decode results are registered on the decode phase.
// Optional macro DECODE_BYPASS_EN: ungated write-back with same-edge forwarding into rs/rt.
module decode_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5
) (
    input logic    clk,
    input logic    rst,
    decode_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] CLS_RALU = 3'd0;
    localparam logic [2:0] CLS_IALU = 3'd1;
    localparam logic [2:0] CLS_LOAD = 3'd2;
    localparam logic [2:0] CLS_STOR = 3'd3;
    localparam logic [2:0] CLS_BRCH = 3'd4;
    localparam logic [2:0] CLS_JUMP = 3'd5;
    localparam logic [2:0] CLS_ILL  = 3'd7;

    logic [DATA_W-1:0] regs_q [0:REG_NUM-1];
    logic [DATA_W-1:0] regs_d [0:REG_NUM-1];
    logic [DATA_W-1:0] ir_q, ir_d, npc_q, npc_d, rs_q, rs_d, rt_q, rt_d;
    logic [DATA_W-1:0] imm_q, imm_d, br_q, br_d, jt_q, jt_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        cls_q, cls_d;
    logic              valid_q, valid_d, ill_q, ill_d;

    logic              ph_fetch_s, ph_dec_s, ph_wb_s, wr_en_s;
    logic [5:0]        opcode_s, funct_s;
    logic [REG_AW-1:0] rs_idx_s, rt_idx_s, rd_s;
    logic [DATA_W-1:0] simm_s, imm_s, rs_rd_s, rt_rd_s;
    logic [2:0]        cls_s;
    logic              ill_s;

    // Exact-value compares make any zero or multi-hot start vector a no-op.
    assign ph_fetch_s = (bus.start == 4'b0001);
    assign ph_dec_s   = (bus.start == 4'b0010);
    assign ph_wb_s    = (bus.start == 4'b1000);
    assign opcode_s   = bus.ir_i[31:26];
    assign funct_s    = bus.ir_i[5:0];
    assign rs_idx_s   = bus.ir_i[25:21];
    assign rt_idx_s   = bus.ir_i[20:16];
    assign simm_s     = {{(DATA_W-16){bus.ir_i[15]}}, bus.ir_i[15:0]};

`ifdef DECODE_BYPASS_EN
    assign wr_en_s = bus.wb_en && (bus.wb_addr != {REG_AW{1'b0}});
`else
    assign wr_en_s = ph_wb_s && bus.wb_en && (bus.wb_addr != {REG_AW{1'b0}});
`endif

    // Register-file read ports; r0 is held at zero so it always reads zero.
    always_comb begin
        rs_rd_s = regs_q[rs_idx_s];
        rt_rd_s = regs_q[rt_idx_s];
`ifdef DECODE_BYPASS_EN
        if (wr_en_s && (bus.wb_addr == rs_idx_s)) begin
            rs_rd_s = bus.wb_data;
        end else begin
            rs_rd_s = regs_q[rs_idx_s];
        end
        if (wr_en_s && (bus.wb_addr == rt_idx_s)) begin
            rt_rd_s = bus.wb_data;
        end else begin
            rt_rd_s = regs_q[rt_idx_s];
        end
`endif
    end

    // Opcode to class / destination / illegal flag.
    always_comb begin
        cls_s = CLS_ILL;
        rd_s  = {REG_AW{1'b0}};
        ill_s = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                rd_s  = bus.ir_i[15:11];
                cls_s = (funct_s == FN_JR) ? CLS_JUMP : CLS_RALU;
            end
            OP_LW:          begin cls_s = CLS_LOAD; rd_s = rt_idx_s; end
            OP_SW:          cls_s = CLS_STOR;
            OP_BEQ, OP_BNE: cls_s = CLS_BRCH;
            OP_J:           cls_s = CLS_JUMP;
            OP_JAL:         begin cls_s = CLS_JUMP; rd_s = REG_AW'(31); end
            default: begin
                if (opcode_s[5:3] == 3'b001) begin
                    cls_s = CLS_IALU;
                    rd_s  = rt_idx_s;
                end else begin
                    cls_s = CLS_ILL;
                    ill_s = 1'b1;
                end
            end
        endcase
    end

    // Immediate extension: logical ops zero-extend, lui shifts up, rest sign-extend.
    always_comb begin
        case (opcode_s)
            OP_ANDI, OP_ORI, OP_XORI: imm_s = {{(DATA_W-16){1'b0}}, bus.ir_i[15:0]};
            OP_LUI:                   imm_s = {bus.ir_i[15:0], {(DATA_W-16){1'b0}}};
            default:                  imm_s = simm_s;
        endcase
    end

    // Register-file next state.
    always_comb begin
        regs_d = regs_q;
        if (wr_en_s) begin
            regs_d[bus.wb_addr] = bus.wb_data;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = {DATA_W{1'b0}};
    end

    // Decode latch next state; outputs hold outside the decode phase.
    always_comb begin
        ir_d = ir_q; npc_d = npc_q; rs_d = rs_q; rt_d = rt_q; imm_d = imm_q;
        br_d = br_q; jt_d = jt_q; rd_d = rd_q; cls_d = cls_q; ill_d = ill_q;
        valid_d = valid_q;
        if (ph_dec_s) begin
            ir_d    = bus.ir_i;
            npc_d   = bus.npc_i;
            rs_d    = rs_rd_s;
            rt_d    = rt_rd_s;
            imm_d   = imm_s;
            br_d    = bus.npc_i + {simm_s[DATA_W-3:0], 2'b00};
            jt_d    = {bus.npc_i[31:28], bus.ir_i[25:0], 2'b00};
            rd_d    = rd_s;
            cls_d   = cls_s;
            ill_d   = ill_s;
            valid_d = 1'b1;
        end else if (ph_fetch_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= {DATA_W{1'b0}};
            ir_q <= '0; npc_q <= '0; rs_q <= '0; rt_q <= '0; imm_q <= '0;
            br_q <= '0; jt_q <= '0; rd_q <= '0; cls_q <= 3'd0; ill_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            ir_q <= ir_d; npc_q <= npc_d; rs_q <= rs_d; rt_q <= rt_d; imm_q <= imm_d;
            br_q <= br_d; jt_q <= jt_d; rd_q <= rd_d; cls_q <= cls_d; ill_q <= ill_d;
            valid_q <= valid_d;
        end
    end

    assign bus.ir_o      = ir_q;
    assign bus.npc_o     = npc_q;
    assign bus.rs_data   = rs_q;
    assign bus.rt_data   = rt_q;
    assign bus.imm_ext   = imm_q;
    assign bus.rd_addr   = rd_q;
    assign bus.op_class  = cls_q;
    assign bus.br_target = br_q;
    assign bus.j_target  = jt_q;
    assign bus.dec_valid = valid_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized + directed bench for decode_stage against a behavioural reference model.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    decode_if dif ();
    decode_stage dut (.clk(clk), .rst(rst), .bus(dif));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] e_ir, e_npc, e_rs, e_rt, e_imm, e_br, e_jt;
    logic [4:0]  e_rd;
    logic [2:0]  e_cls;
    logic        e_ill, e_vld;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        e_ir = 32'd0; e_npc = 32'd0; e_rs = 32'd0; e_rt = 32'd0; e_imm = 32'd0;
        e_br = 32'd0; e_jt = 32'd0; e_rd = 5'd0; e_cls = 3'd0; e_ill = 1'b0; e_vld = 1'b0;
    endtask

    // Reference: what one clock edge does to the architectural state.
    task automatic model_edge(input logic [3:0] s, input logic [31:0] ir, input logic [31:0] npc,
                              input logic en, input logic [4:0] a, input logic [31:0] d);
        bit wr;
        int op, fn, s16;
        logic [31:0] simm;
`ifdef DECODE_BYPASS_EN
        wr = en && (a != 5'd0);
`else
        wr = (s == 4'b1000) && en && (a != 5'd0);
`endif
        if (s == 4'b0010) begin
            op = int'(ir[31:26]);
            fn = int'(ir[5:0]);
            s16 = int'($signed(ir[15:0]));
            simm = s16;
            e_ir = ir; e_npc = npc; e_vld = 1'b1;
            e_rs = m_regs[ir[25:21]];
            e_rt = m_regs[ir[20:16]];
`ifdef DECODE_BYPASS_EN
            if (wr && a == ir[25:21]) e_rs = d;
            if (wr && a == ir[20:16]) e_rt = d;
`endif
            if (op == 12 || op == 13 || op == 14) e_imm = ir & 32'h0000FFFF;
            else if (op == 15) e_imm = (ir & 32'h0000FFFF) * 32'd65536;
            else e_imm = simm;
            e_br = npc + simm * 32'd4;
            e_jt = (npc & 32'hF0000000) | ((ir & 32'h03FFFFFF) * 32'd4);
            e_ill = 1'b0; e_rd = 5'd0;
            if (op == 0) begin e_cls = (fn == 8) ? 3'd5 : 3'd0; e_rd = ir[15:11]; end
            else if (op >= 8 && op <= 15) begin e_cls = 3'd1; e_rd = ir[20:16]; end
            else if (op == 35) begin e_cls = 3'd2; e_rd = ir[20:16]; end
            else if (op == 43) e_cls = 3'd3;
            else if (op == 4 || op == 5) e_cls = 3'd4;
            else if (op == 2) e_cls = 3'd5;
            else if (op == 3) begin e_cls = 3'd5; e_rd = 5'd31; end
            else begin e_cls = 3'd7; e_ill = 1'b1; end
        end else if (s == 4'b0001) begin
            e_vld = 1'b0;
        end
        if (wr) m_regs[a] = d;
    endtask

    task automatic check_all();
        check_val("ir_o", dif.ir_o, e_ir);
        check_val("npc_o", dif.npc_o, e_npc);
        check_val("rs_data", dif.rs_data, e_rs);
        check_val("rt_data", dif.rt_data, e_rt);
        check_val("imm_ext", dif.imm_ext, e_imm);
        check_val("rd_addr", {27'd0, dif.rd_addr}, {27'd0, e_rd});
        check_val("op_class", {29'd0, dif.op_class}, {29'd0, e_cls});
        check_val("br_target", dif.br_target, e_br);
        check_val("j_target", dif.j_target, e_jt);
        check_val("dec_valid", {31'd0, dif.dec_valid}, {31'd0, e_vld});
        check_val("illegal", {31'd0, dif.illegal}, {31'd0, e_ill});
    endtask

    task automatic cyc(input logic [3:0] s, input logic [31:0] ir, input logic [31:0] npc,
                       input logic en, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        dif.start = s; dif.ir_i = ir; dif.npc_i = npc;
        dif.wb_en = en; dif.wb_addr = a; dif.wb_data = d;
        @(posedge clk);
        model_edge(s, ir, npc, en, a, d);
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_ir();
        logic [5:0] ops [12];
        logic [31:0] r;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
        r = $urandom;
        if ($urandom_range(0, 4) != 0) r[31:26] = ops[$urandom_range(0, 11)];
        if (r[31:26] == 6'h00 && $urandom_range(0, 3) == 0) r[5:0] = 6'b001000;
        return r;
    endfunction

    function automatic logic [3:0] rand_start();
        int k;
        k = $urandom_range(0, 9);
        if (k < 2) return 4'b0001;
        else if (k < 5) return 4'b0010;
        else if (k < 6) return 4'b0100;
        else if (k < 8) return 4'b1000;
        else if (k < 9) return 4'($urandom_range(0, 15));
        else return 4'b0000;
    endfunction

    logic [31:0] r_ir, r_npc, r_d;

    initial begin
        rst = 1'b0;
        dif.start = 4'b0000; dif.ir_i = 32'd0; dif.npc_i = 32'd0;
        dif.wb_en = 1'b0; dif.wb_addr = 5'd0; dif.wb_data = 32'd0;
        model_reset();
        #100;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Every register reads zero after reset.
        for (int i = 1; i < 32; i++) cyc(4'b0010, {6'd0, 5'(i), 5'(i), 5'd1, 11'h020}, 32'd4, 1'b0, 5'd0, 32'd0);

        cyc(4'b1000, 32'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        cyc(4'b0010, 32'h00A53020, 32'd4, 1'b0, 5'd0, 32'd0);
        check_val("add_rs", dif.rs_data, 32'hDEADBEEF);
        check_val("add_rt", dif.rt_data, 32'hDEADBEEF);
        check_val("add_rd", {27'd0, dif.rd_addr}, 32'd6);
        check_val("add_cls", {29'd0, dif.op_class}, 32'd0);
        check_val("add_vld", {31'd0, dif.dec_valid}, 32'd1);
        cyc(4'b0100, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_val("vld_hold_ex", {31'd0, dif.dec_valid}, 32'd1);
        cyc(4'b0001, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_val("vld_clr_fetch", {31'd0, dif.dec_valid}, 32'd0);

        cyc(4'b0010, 32'h2001FFFF, 32'd8, 1'b0, 5'd0, 32'd0);
        check_val("addi_imm", dif.imm_ext, 32'hFFFFFFFF);
        cyc(4'b0010, 32'h3401FFFF, 32'd8, 1'b0, 5'd0, 32'd0);
        check_val("ori_imm", dif.imm_ext, 32'h0000FFFF);
        cyc(4'b0010, 32'h3C011234, 32'd8, 1'b0, 5'd0, 32'd0);
        check_val("lui_imm", dif.imm_ext, 32'h12340000);

        cyc(4'b0010, 32'h1000FFFF, 32'hC0000000, 1'b0, 5'd0, 32'd0);
        check_val("beq_tgt", dif.br_target, 32'hBFFFFFFC);
        cyc(4'b0010, 32'h0C000010, 32'hC0000000, 1'b0, 5'd0, 32'd0);
        check_val("jal_tgt", dif.j_target, 32'hC0000040);
        check_val("jal_rd", {27'd0, dif.rd_addr}, 32'd31);
        check_val("jal_cls", {29'd0, dif.op_class}, 32'd5);
        cyc(4'b0010, 32'h10000001, 32'hFFFFFFFC, 1'b0, 5'd0, 32'd0);
        check_val("br_wrap", dif.br_target, 32'd0);

        cyc(4'b1000, 32'd0, 32'd0, 1'b1, 5'd0, 32'h12345678);
        cyc(4'b0010, 32'h00000020, 32'd4, 1'b0, 5'd0, 32'd0);
        check_val("r0_zero", dif.rs_data, 32'd0);
        cyc(4'b0010, 32'hFC000000, 32'd4, 1'b0, 5'd0, 32'd0);
        check_val("ill_flag", {31'd0, dif.illegal}, 32'd1);
        check_val("ill_cls", {29'd0, dif.op_class}, 32'd7);
        cyc(4'b0110, 32'h00A53020, 32'h55555555, 1'b0, 5'd0, 32'd0);
        check_val("multihot_ir", dif.ir_o, 32'hFC000000);

        // Same-edge write and decode of r7.
        cyc(4'b1000, 32'd0, 32'd0, 1'b1, 5'd7, 32'h0000AAAA);
        cyc(4'b0010, 32'h00E03820, 32'd4, 1'b1, 5'd7, 32'h0000BBBB);
`ifdef DECODE_BYPASS_EN
        check_val("same_edge_rs", dif.rs_data, 32'h0000BBBB);
`else
        check_val("same_edge_rs", dif.rs_data, 32'h0000AAAA);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r_ir = rand_ir(); r_npc = $urandom; r_d = $urandom;
            cyc(rand_start(), r_ir, r_npc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), r_d);
        end

        // Asynchronous reset in the middle of a phase.
        cyc(4'b0010, 32'h00A53020, 32'd4, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_vld", {31'd0, dif.dec_valid}, 32'd0);
        check_all();
        #1 rst = 1'b1;
        cyc(4'b0010, 32'h00A53020, 32'd4, 1'b0, 5'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the multi-cycle MIPS-style CPU; sits directly downstream of the fetch stage.
- Consumes the fetched instruction (ir) and next PC (npc) in the decode phase of the 4-phase one-hot timing vector from the clock generator.
- Contains the 32x32 general register file and registers the decoded operands, immediate, destination and control class for the execute stage.
- Accepts register write-back from the write-back stage.

Parameters:
DATA_W, 32, datapath / register width
REG_NUM, 32, number of general registers (r0 hardwired zero)
REG_AW, 5, register address width

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
start  input  4  one-hot phase vector: [0] fetch, [1] decode, [2] execute, [3] write-back
ir_i  input  32  instruction from fetch
npc_i  input  32  next PC (PC+4) from fetch
wb_en  input  1  register write request
wb_addr  input  5  write register index
wb_data  input  32  write data
ir_o  output  32  latched instruction
npc_o  output  32  latched npc
rs_data  output  32  register[ir[25:21]]
rt_data  output  32  register[ir[20:16]]
imm_ext  output  32  extended immediate
rd_addr  output  5  destination register index
op_class  output  3  0 R-ALU, 1 I-ALU, 2 load, 3 store, 4 branch, 5 jump, 7 illegal
br_target  output  32  npc + (sign-extended imm << 2)
j_target  output  32  {npc[31:28], ir[25:0], 2'b00}
dec_valid  output  1  decoded outputs valid
illegal  output  1  unrecognised opcode

Behaviour:
- rst low (async): every output 0, all registers 0, dec_valid 0. A reset mid-decode discards the latched instruction.
- Phase decoding: act only when start is exactly one-hot. A zero or multi-bit start causes no action; all state holds.
- Decode latch, on the rising clk edge with start[1]=1: capture ir_i and npc_i, read rs/rt from the register file, and register all decoded outputs.
  - Latency is 1 edge; dec_valid=1 after that edge.
- dec_valid clears on the edge with start[0]=1 (new fetch). It holds through start[2] and start[3].
- Register write, on the edge with start[3]=1, wb_en=1 and wb_addr!=0: reg[wb_addr] <= wb_data.
  - Writes to r0 are ignored; reads of r0 return 0.
- Opcode ir[31:26] decode:
  - 000000: R-ALU with rd_addr=ir[15:11]; if funct=001000 (jr), class 5 instead.
  - 001xxx: I-ALU, rd_addr=ir[20:16].
  - 100011: load, rd_addr=ir[20:16].
  - 101011: store, rd_addr=0.
  - 000100 / 000101: branch, rd_addr=0.
  - 000010: jump, rd_addr=0.
  - 000011: jal, rd_addr=31.
  - Anything else: op_class=7, illegal=1, rd_addr=0.
- imm_ext rules:
  - Zero-extend ir[15:0] for 001100, 001101, 001110.
  - {ir[15:0], 16'h0} for 001111.
  - Sign-extend otherwise.
- br_target: always computed from the sign-extended immediate, modulo 2^32 (wrap-around, no flag).
- Outputs hold stable from the decode edge until the next decode edge or reset.

Optional Feature:
DECODE_BYPASS_EN
- Defined:
  - Write-back is accepted on any edge with wb_en=1 (not gated by start[3]).
  - If a write and a decode latch occur on the same edge and wb_addr (non-zero) matches the rs or rt index, the corresponding rs_data / rt_data take wb_data.
- Undefined:
  - wb_en is ignored outside start[3].
  - A same-edge write is not visible to the concurrent decode, which reads the old value.

Test Plan:
1. Reset: rst=0 for 100 ns, then 1 -> all outputs 0, dec_valid 0, and reading r1..r31 via decode gives 0.
2. Write then read: start[3] with wb_en=1, wb_addr=5, wb_data=32'hDEADBEEF. Next start[1] with ir_i=32'h00A53020 (add r6,r5,r5) -> rs_data=rt_data=32'hDEADBEEF, rd_addr=6, op_class=0, dec_valid=1.
3. Immediates: ir_i=32'h2001FFFF (addi) -> imm_ext=32'hFFFFFFFF. ir_i=32'h3401FFFF (ori) -> 32'h0000FFFF. ir_i=32'h3C011234 (lui) -> 32'h12340000.
4. Branch/jump targets with npc_i=32'hBFFFFFFF+1=32'hC0000000:
   - beq with imm 16'hFFFF -> br_target=32'hBFFFFFFC.
   - jal ir_i=32'h0C000010 -> j_target=32'hC0000040, rd_addr=31, op_class=5.
   - npc=32'hFFFFFFFC with imm 1 -> br_target=0 (wrap-around).
5. Guards:
   - wb_addr=0 write, then decode of rs=0 -> rs_data=0.
   - opcode 111111 -> illegal=1, op_class=7.
   - start=4'b0110 -> no state change.
6. Same-edge write+decode of r7 (only meaningful with the forced stimulus):
   - With DECODE_BYPASS_EN -> rs_data=new value.
   - Without -> write ignored (not start[3]) and rs_data=old value.
   - Also: assert rst low mid-phase -> dec_valid=0 immediately.
